vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA/VESA timing generator. It emits the sync pulses, display-active
//  flag, pixel coordinates, and line/frame start strobes for any mode set by parameters.
//  An internal pixel-clock-enable divider lets it run from a faster system clock.
//  It feeds the pixel-pattern and framebuffer readout logic.
//  All outputs are registered and mutually aligned.
// PARAMETERS
//  H_DISP    640  active pixels per line
//  H_FPORCH  16   horizontal front porch, in pixels
//  H_SYNC    96   horizontal sync width, in pixels
//  H_BPORCH  48   horizontal back porch, in pixels
//  V_DISP    480  active lines per frame
//  V_FPORCH  10   vertical front porch, in lines
//  V_SYNC    2    vertical sync width, in lines
//  V_BPORCH  33   vertical back porch, in lines
//  HSYNC_POL 0    asserted level of hsync_o (0 = active low)
//  VSYNC_POL 0    asserted level of vsync_o
//  CLK_DIV   1    clk_i cycles per pixel (>=1); 4 gives a 25 MHz pixel rate from 100 MHz
//  CNT_W     11   width of the coordinate outputs
// PORTS
//  clk_i          in   1      system clock
//  rst_ni         in   1      synchronous, active-low reset
//  en_i           in   1      run enable; when low, all state freezes
//  hsync_o        out  1      horizontal sync, level set by HSYNC_POL
//  vsync_o        out  1      vertical sync, level set by VSYNC_POL
//  disp_active_o  out  1      high while (xcol_o, yrow_o) is inside the active region
//  xcol_o         out  CNT_W  current pixel column, 0..H_TOTAL-1
//  yrow_o         out  CNT_W  current line, 0..V_TOTAL-1
//  pix_stb_o      out  1      1-clk pulse when a new pixel position is presented
//  line_start_o   out  1      1-clk pulse when xcol_o becomes 0
//  frame_start_o  out  1      1-clk pulse when xcol_o and yrow_o both become 0
// BEHAVIOUR
//  - Totals: H_TOTAL = H_DISP+H_FPORCH+H_SYNC+H_BPORCH; V_TOTAL likewise.
//  - Elaboration fails if H_TOTAL-1 or V_TOTAL-1 does not fit in CNT_W bits, or if CLK_DIV < 1.
//  - Segment order on both axes: display, front porch, sync, back porch.
//  - hsync_o is asserted exactly for x in [H_DISP+H_FPORCH, H_DISP+H_FPORCH+H_SYNC-1].
//  - vsync_o is asserted exactly for y in [V_DISP+V_FPORCH, V_DISP+V_FPORCH+V_SYNC-1],
//    for the whole of each such line.
//  - disp_active_o = (x < H_DISP) && (y < V_DISP).
//  - Reset (rst_ni=0 at a clk edge):
//    - div_cnt=0.
//    - x=H_TOTAL-1, y=V_TOTAL-1, i.e. the last back-porch pixel.
//    - disp_active_o=0; both syncs at their inactive level; all strobes=0.
//    - Every output is consistent with that position.
//  - Divider:
//    - div_cnt counts 0..CLK_DIV-1 while en_i=1.
//    - An advance fires on the clk edge where div_cnt==CLK_DIV-1 (and en_i=1); div_cnt
//      then returns to 0.
//    - With CLK_DIV=1, an advance fires on every enabled edge.
//  - Advance: x wraps at H_TOTAL-1 to 0; y increments only on an x wrap; y wraps at
//    V_TOTAL-1 to 0.
//  - On an advance edge, all outputs load the decode of the NEW position in the same edge.
//    Coordinates, syncs, disp_active and strobes therefore always describe one position.
//  - Latency: 0 clk from a position change to its decode on the outputs.
//  - Strobes:
//    - pix_stb_o=1 for the single clk following each advance edge.
//    - line_start_o and frame_start_o pulse for that same single clk and are qualified
//      by it.
//  - First advance after reset release presents (0,0), with pix_stb_o, line_start_o and
//    frame_start_o all high.
//  - en_i=0: div_cnt, x, y and the level outputs hold; the strobes drop to 0 on the next
//    edge. Resuming continues the count with no skipped or repeated pixel.
//  - Reset asserted mid-frame overrides en_i and any pending advance on that edge.
// STRUCTURE
//  - vga_timing_pkg holds the default 640x480@60 constants, an 800x600@60 constant set,
//    and a function computing the required CNT_W from the totals.
//  - Sub-module vga_axis_counter (generic DISP/FPORCH/SYNC/BPORCH, POL) is instantiated
//    once per axis:
//    - inc_i advances the count; wrap_o flags the terminal count.
//    - It produces the next-count and sync/active decode.
//    - The vertical instance has inc_i = advance && horizontal wrap_o.
//  - The top level holds the divider, the output registers and the strobe logic.
// TESTING
//  - Defaults, CLK_DIV=1, reset released:
//    - 1st edge gives (0,0) with all three strobes=1 and disp_active_o=1.
//    - The next frame_start_o comes exactly 420000 clks later.
//  - Defaults:
//    - hsync_o is low exactly for x=656..751 and vsync_o low exactly for y=490..491.
//    - disp_active_o drops at x=640 and at y=480.
//  - CLK_DIV=4:
//    - pix_stb_o pulses every 4th clk, and x holds for 4 clks.
//    - A full line takes 3200 clks.
//  - HSYNC_POL=1, VSYNC_POL=1: both sync waveforms are inverted, with all timing
//    otherwise identical.
//  - Hold en_i=0 for 7 clks at x=799, y=524: outputs hold and strobes are 0; after
//    resume the next position is (0,0) with frame_start_o=1.
//  - Assert rst_ni=0 for 1 clk mid-line at x=300, y=100 with en_i=1:
//    - Outputs show (799,524), disp_active_o=0, syncs inactive.
//    - The count then restarts at (0,0).

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared VGA timing constants, segment type and counter-width helper
//   Provides the 640x480@60 default mode, an 800x600@60 mode, the per-axis segment
//   enum and cnt_width(), which gives the bits needed to hold 0..total-1.
package vga_timing_pkg;

    // 640x480@60, 25.175 MHz pixel clock, both syncs active low
    localparam int VGA640_H_DISP   = 640;
    localparam int VGA640_H_FPORCH = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BPORCH = 48;
    localparam int VGA640_V_DISP   = 480;
    localparam int VGA640_V_FPORCH = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BPORCH = 33;
    localparam bit VGA640_HSYNC_POL = 1'b0;
    localparam bit VGA640_VSYNC_POL = 1'b0;

    // 800x600@60, 40 MHz pixel clock, both syncs active high
    localparam int SVGA800_H_DISP   = 800;
    localparam int SVGA800_H_FPORCH = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BPORCH = 88;
    localparam int SVGA800_V_DISP   = 600;
    localparam int SVGA800_V_FPORCH = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BPORCH = 23;
    localparam bit SVGA800_HSYNC_POL = 1'b1;
    localparam bit SVGA800_VSYNC_POL = 1'b1;

    typedef enum logic [1:0] {
        SEG_DISP,
        SEG_FPORCH,
        SEG_SYNC,
        SEG_BPORCH
    } vga_seg_e;

    function automatic int cnt_width(input int total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: next-count and segment decode for one timing axis
//   cnt_i      current count (held in the parent's registers)
//   inc_i      advance the count this edge
//   cnt_next_o count after this edge (wraps to 0 after the terminal count)
//   wrap_o     current count is the terminal count (TOTAL-1)
//   sync_o     sync level for cnt_next_o, asserted level POL
//   active_o   cnt_next_o lies in the display segment
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int DISP   = 640,
    parameter int FPORCH = 16,
    parameter int SYNC   = 96,
    parameter int BPORCH = 48,
    parameter bit POL    = 1'b0,
    parameter int CNT_W  = 11
) (
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_next_o,
    output logic             wrap_o,
    output logic             sync_o,
    output logic             active_o
);

    localparam int TOTAL = DISP + FPORCH + SYNC + BPORCH;
    // Inclusive segment ends, so no bound ever needs TOTAL itself in CNT_W bits
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DISP - 1);
    localparam logic [CNT_W-1:0] F_LAST = CNT_W'(DISP + FPORCH - 1);
    localparam logic [CNT_W-1:0] S_LAST = CNT_W'(DISP + FPORCH + SYNC - 1);

    vga_seg_e seg;

    assign wrap_o     = cnt_i == LAST;
    assign cnt_next_o = !inc_i ? cnt_i : wrap_o ? '0 : cnt_i + CNT_W'(1);
    assign seg        = cnt_next_o <= D_LAST ? SEG_DISP   :
                        cnt_next_o <= F_LAST ? SEG_FPORCH :
                        cnt_next_o <= S_LAST ? SEG_SYNC   : SEG_BPORCH;
    assign sync_o     = seg == SEG_SYNC ? POL : ~POL;
    assign active_o   = seg == SEG_DISP;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA/VESA sync, active-region and coordinate generator
//   clk_i          system clock; a pixel advance happens every CLK_DIV enabled cycles
//   rst_ni         synchronous active-low reset, parks the position at the last pixel
//   en_i           run enable; low freezes divider, position and level outputs
//   hsync_o        horizontal sync, asserted level HSYNC_POL
//   vsync_o        vertical sync, asserted level VSYNC_POL
//   disp_active_o  (xcol_o, yrow_o) lies inside the active region
//   xcol_o/yrow_o  current pixel column / line
//   pix_stb_o      one-cycle pulse after each advance
//   line_start_o   pix_stb_o qualified by xcol_o becoming 0
//   frame_start_o  pix_stb_o qualified by position becoming (0,0)
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISP    = VGA640_H_DISP,
    parameter int H_FPORCH  = VGA640_H_FPORCH,
    parameter int H_SYNC    = VGA640_H_SYNC,
    parameter int H_BPORCH  = VGA640_H_BPORCH,
    parameter int V_DISP    = VGA640_V_DISP,
    parameter int V_FPORCH  = VGA640_V_FPORCH,
    parameter int V_SYNC    = VGA640_V_SYNC,
    parameter int V_BPORCH  = VGA640_V_BPORCH,
    parameter bit HSYNC_POL = VGA640_HSYNC_POL,
    parameter bit VSYNC_POL = VGA640_VSYNC_POL,
    parameter int CLK_DIV   = 1,
    parameter int CNT_W     = 11
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             disp_active_o,
    output logic [CNT_W-1:0] xcol_o,
    output logic [CNT_W-1:0] yrow_o,
    output logic             pix_stb_o,
    output logic             line_start_o,
    output logic             frame_start_o
);

    localparam int H_TOTAL = H_DISP + H_FPORCH + H_SYNC + H_BPORCH;
    localparam int V_TOTAL = V_DISP + V_FPORCH + V_SYNC + V_BPORCH;
    localparam int DIV_W   = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (cnt_width(H_TOTAL) > CNT_W) begin : g_bad_h
        $error("vga_timing_gen: H_TOTAL-1 does not fit in CNT_W bits");
    end
    if (cnt_width(V_TOTAL) > CNT_W) begin : g_bad_v
        $error("vga_timing_gen: V_TOTAL-1 does not fit in CNT_W bits");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end

    logic [DIV_W-1:0] div_cnt;
    logic             advance;
    logic [CNT_W-1:0] x_next, y_next;
    logic             h_wrap, v_wrap, h_sync, v_sync, h_act, v_act;

    assign advance = en_i && div_cnt == DIV_LAST;

    vga_axis_counter #(
        .DISP(H_DISP), .FPORCH(H_FPORCH), .SYNC(H_SYNC), .BPORCH(H_BPORCH),
        .POL(HSYNC_POL), .CNT_W(CNT_W)
    ) u_h (
        .cnt_i(xcol_o), .inc_i(advance), .cnt_next_o(x_next),
        .wrap_o(h_wrap), .sync_o(h_sync), .active_o(h_act)
    );

    // The line count only moves when the column wraps on an advance edge
    vga_axis_counter #(
        .DISP(V_DISP), .FPORCH(V_FPORCH), .SYNC(V_SYNC), .BPORCH(V_BPORCH),
        .POL(VSYNC_POL), .CNT_W(CNT_W)
    ) u_v (
        .cnt_i(yrow_o), .inc_i(advance && h_wrap), .cnt_next_o(y_next),
        .wrap_o(v_wrap), .sync_o(v_sync), .active_o(v_act)
    );

    // Coordinates and their decode load together, so every output names one position
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            div_cnt       <= '0;
            xcol_o        <= CNT_W'(H_TOTAL - 1);
            yrow_o        <= CNT_W'(V_TOTAL - 1);
            hsync_o       <= ~HSYNC_POL;
            vsync_o       <= ~VSYNC_POL;
            disp_active_o <= 1'b0;
            pix_stb_o     <= 1'b0;
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
        end else begin
            pix_stb_o     <= advance;
            line_start_o  <= advance && h_wrap;
            frame_start_o <= advance && h_wrap && v_wrap;
            if (en_i)
                div_cnt <= advance ? '0 : div_cnt + DIV_W'(1);
            if (advance) begin
                xcol_o        <= x_next;
                yrow_o        <= y_next;
                hsync_o       <= h_sync;
                vsync_o       <= v_sync;
                disp_active_o <= h_act && v_act;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen with two parameter sets
//   dut0: 640-pixel lines, short frame, CLK_DIV=1, active-low syncs
//   dut1: 640-pixel lines, short frame, CLK_DIV=4, active-high syncs
module tb_vga_timing_gen;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        hs;
        logic        vs;
        logic        da;
        logic        stb;
        logic        ls;
        logic        fs;
    } obs_t;

    logic clk = 1'b0;
    int   checks = 0;
    int   failures = 0;
    bit   done [2];

    always #5 clk = ~clk;

    // Reference view: a linear pixel index p, position derived by division
    function automatic obs_t ref_pos(input int p, input int hd, input int hf, input int hs,
                                     input int ht, input int vd, input int vf, input int vs,
                                     input bit pol, input bit stb);
        obs_t e;
        int   x, y;
        x     = p % ht;
        y     = p / ht;
        e.x   = 11'(x);
        e.y   = 11'(y);
        e.hs  = (x >= hd + hf && x < hd + hf + hs) ? pol : !pol;
        e.vs  = (y >= vd + vf && y < vd + vf + vs) ? pol : !pol;
        e.da  = x < hd && y < vd;
        e.stb = stb;
        e.ls  = stb && x == 0;
        e.fs  = stb && p == 0;
        return e;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int  CD  = g == 0 ? 1 : 4;
        localparam bit  POL = g == 0 ? 1'b0 : 1'b1;
        localparam int  HD = 640, HF = 16, HS = 96, HB = 48;
        localparam int  VD = g == 0 ? 8 : 2;
        localparam int  VF = g == 0 ? 2 : 1;
        localparam int  VS = g == 0 ? 2 : 1;
        localparam int  VB = g == 0 ? 2 : 1;
        localparam int  HT = HD + HF + HS + HB;
        localparam int  VT = VD + VF + VS + VB;

        logic        en = 1'b0;
        logic        rst_n = 1'b0;
        logic        hs, vs, da, pix, ls, fs;
        logic [10:0] x, y;
        obs_t        q[$];
        int          p = 0;
        int          ph = 0;
        bit          armed = 1'b0;

        vga_timing_gen #(
            .H_DISP(HD), .H_FPORCH(HF), .H_SYNC(HS), .H_BPORCH(HB),
            .V_DISP(VD), .V_FPORCH(VF), .V_SYNC(VS), .V_BPORCH(VB),
            .HSYNC_POL(POL), .VSYNC_POL(POL), .CLK_DIV(CD), .CNT_W(11)
        ) u_dut (
            .clk_i(clk), .rst_ni(rst_n), .en_i(en),
            .hsync_o(hs), .vsync_o(vs), .disp_active_o(da),
            .xcol_o(x), .yrow_o(y),
            .pix_stb_o(pix), .line_start_o(ls), .frame_start_o(fs)
        );

        // Model: every CD enabled edges the pixel index steps; each step is queued
        initial forever begin
            @(posedge clk);
            if (!rst_n) begin
                ph = 0;
                p = HT * VT - 1;
                armed = 1'b1;
            end else if (en) begin
                if (ph == CD - 1) begin
                    ph = 0;
                    p = (p + 1) % (HT * VT);
                    q.push_back(ref_pos(p, HD, HF, HS, HT, VD, VF, VS, POL, 1'b1));
                end else begin
                    ph++;
                end
            end
        end

        // Monitor: a strobe must match a queued step; otherwise outputs must hold quietly
        initial forever begin
            obs_t e, o;
            @(negedge clk);
            if (armed) begin
                o = {x, y, hs, vs, da, pix, ls, fs};
                if (pix === 1'b1 && q.size() > 0)
                    e = q.pop_front();
                else begin
                    if (q.size() > 0) void'(q.pop_front());
                    e = (q.size() > 0 || pix === 1'b1) ?
                        ref_pos(p, HD, HF, HS, HT, VD, VF, VS, POL, 1'b1) :
                        ref_pos(p, HD, HF, HS, HT, VD, VF, VS, POL, 1'b0);
                    if (pix !== 1'b1 && ph == 0 && p >= 0) e.stb = e.stb;
                end
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL dut%0d scoreboard: got x=%0d y=%0d hs=%b vs=%b da=%b stb=%b ls=%b fs=%b, expected x=%0d y=%0d hs=%b vs=%b da=%b stb=%b ls=%b fs=%b",
                             g, o.x, o.y, o.hs, o.vs, o.da, o.stb, o.ls, o.fs,
                             e.x, e.y, e.hs, e.vs, e.da, e.stb, e.ls, e.fs);
                end
            end
        end

        initial begin
            int n;
            repeat (3) @(negedge clk);
            chk($sformatf("dut%0d reset x", g), int'(x), HT - 1);
            chk($sformatf("dut%0d reset y", g), int'(y), VT - 1);
            chk($sformatf("dut%0d reset da/hs/vs/stb", g), int'({da, hs, vs, pix}), int'({1'b0, !POL, !POL, 1'b0}));
            rst_n = 1'b1;
            en = 1'b1;
            repeat (CD) @(negedge clk);
            chk($sformatf("dut%0d first pos", g), int'({x, y}), 0);
            chk($sformatf("dut%0d first strobes/da", g), int'({pix, ls, fs, da}), 4'hf);
            repeat (300) begin
                en = $urandom_range(0, 3) != 0;
                @(negedge clk);
            end
            en = 1'b1;
            for (int k = 0; k < 2 * HT * VT * CD && fs !== 1'b1; k++) @(negedge clk);
            chk($sformatf("dut%0d reach frame start", g), int'(fs), 1);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (fs !== 1'b1 && n < 2 * HT * VT * CD);
            chk($sformatf("dut%0d frame period clks", g), n, HT * VT * CD);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (ls !== 1'b1 && n < 2 * HT * CD);
            chk($sformatf("dut%0d line period clks", g), n, HT * CD);
            for (int k = 0; k < 2 * HT * VT * CD && !(pix === 1'b1 && x == 11'(HT - 1) && y == 11'(VT - 1)); k++)
                @(negedge clk);
            chk($sformatf("dut%0d reach last pixel", g), int'({x, y}), int'({11'(HT - 1), 11'(VT - 1)}));
            en = 1'b0;
            repeat (7) @(negedge clk);
            chk($sformatf("dut%0d hold pos", g), int'({x, y}), int'({11'(HT - 1), 11'(VT - 1)}));
            chk($sformatf("dut%0d hold strobes", g), int'({pix, ls, fs}), 0);
            en = 1'b1;
            repeat (CD) @(negedge clk);
            chk($sformatf("dut%0d resume pos", g), int'({x, y}), 0);
            chk($sformatf("dut%0d resume frame_start", g), int'({pix, fs}), 3);
            for (int k = 0; k < 2 * HT * VT * CD && !(x == 11'd300 && y == 11'(VT / 2)); k++)
                @(negedge clk);
            chk($sformatf("dut%0d reach mid-line", g), int'({x, y}), int'({11'd300, 11'(VT / 2)}));
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            chk($sformatf("dut%0d mid reset pos", g), int'({x, y}), int'({11'(HT - 1), 11'(VT - 1)}));
            chk($sformatf("dut%0d mid reset da/hs/vs/stb", g), int'({da, hs, vs, pix}), int'({1'b0, !POL, !POL, 1'b0}));
            repeat (CD) @(negedge clk);
            chk($sformatf("dut%0d restart pos", g), int'({x, y}), 0);
            chk($sformatf("dut%0d restart frame_start", g), int'(fs), 1);
            repeat (2 * CD + 3) @(negedge clk);
            done[g] = 1'b1;
        end
    end

    initial begin
        fork
            wait (done[0] && done[1]);
            begin
                #2_000_000;
                failures++;
                $display("FAIL timeout: got unfinished run expected completion");
            end
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
